// File: rtl/m_enc_imm.sv
// m_enc_imm: packs decoded RV32I fields into an instruction word and
// streams it out through one registered stage with a sequential address.
module m_enc_imm #(
    parameter int ADDR_W = 10,
    parameter int BASE   = 0
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              w_in_valid,
    output logic              w_in_ready,
    input  logic [2:0]        w_fmt,
    input  logic [6:0]        w_opc,
    input  logic [4:0]        w_rd,
    input  logic [4:0]        w_rs1,
    input  logic [4:0]        w_rs2,
    input  logic [2:0]        w_f3,
    input  logic [6:0]        w_f7,
    input  logic [31:0]       w_imm,
    output logic              w_out_valid,
    input  logic              w_out_ready,
    output logic [31:0]       w_ir,
    output logic [ADDR_W-1:0] w_addr,
    output logic              w_err,
    output logic [7:0]        w_err_cnt
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);

    logic        accept;
    logic        handoff;
    logic        legal;
    logic        imm_ok;
    logic        fits12;
    logic        fits13;
    logic        fits21;
    logic [31:0] enc;

    assign w_in_ready = !w_out_valid || w_out_ready;
    assign accept     = w_in_valid && w_in_ready;
    assign handoff    = w_out_valid && w_out_ready;

    // The immediate must round-trip through the field the format stores.
    assign fits12 = (w_imm == {{20{w_imm[11]}}, w_imm[11:0]});
    assign fits13 = (w_imm == {{19{w_imm[12]}}, w_imm[12:0]});
    assign fits21 = (w_imm == {{11{w_imm[20]}}, w_imm[20:0]});

    always_comb begin
        enc    = 32'd0;
        imm_ok = 1'b0;
        unique case (w_fmt)
            FMT_R: begin
                enc    = {w_f7, w_rs2, w_rs1, w_f3, w_rd, w_opc};
                imm_ok = 1'b1;
            end
            FMT_I: begin
                enc    = {w_imm[11:0], w_rs1, w_f3, w_rd, w_opc};
                imm_ok = fits12;
            end
            FMT_S: begin
                enc    = {w_imm[11:5], w_rs2, w_rs1, w_f3,
                          w_imm[4:0], w_opc};
                imm_ok = fits12;
            end
            FMT_B: begin
                enc    = {w_imm[12], w_imm[10:5], w_rs2, w_rs1, w_f3,
                          w_imm[4:1], w_imm[11], w_opc};
                imm_ok = !w_imm[0] && fits13;
            end
            FMT_U: begin
                enc    = {w_imm[31:12], w_rd, w_opc};
                imm_ok = (w_imm[11:0] == 12'd0);
            end
            FMT_J: begin
                enc    = {w_imm[20], w_imm[10:1], w_imm[11],
                          w_imm[19:12], w_rd, w_opc};
                imm_ok = !w_imm[0] && fits21;
            end
            default: begin
                enc    = 32'd0;
                imm_ok = 1'b0;
            end
        endcase
    end

    assign legal = imm_ok && (w_opc[1:0] == 2'b11);

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            w_out_valid <= 1'b0;
            w_ir        <= 32'd0;
            w_addr      <= BASE_A;
        end else begin
            if (handoff) begin
                w_addr <= w_addr + ADDR_W'(1);
            end
            if (accept && legal) begin
                w_ir        <= enc;
                w_out_valid <= 1'b1;
            end else if (handoff) begin
                w_out_valid <= 1'b0;
            end
        end
    end

    // Dropped inputs are only counted; nothing else reacts to them.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            w_err     <= 1'b0;
            w_err_cnt <= 8'd0;
        end else if (accept && !legal) begin
            w_err <= 1'b1;
            if (w_err_cnt != 8'hFF) begin
                w_err_cnt <= w_err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_m_enc_imm.sv
// tb_m_enc_imm: randomized scoreboard bench for m_enc_imm, with a second
// instance using a 2-bit address to exercise wrap-around.
module tb_m_enc_imm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  fmt = '0;
    logic [6:0]  opc = '0;
    logic [4:0]  rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [2:0]  f3 = '0;
    logic [6:0]  f7 = '0;
    logic [31:0] imm = '0;

    logic        in_ready, out_valid, err;
    logic [31:0] ir;
    logic [9:0]  addr;
    logic [7:0]  err_cnt;

    logic        in_ready_w, out_valid_w, err_w;
    logic [31:0] ir_w;
    logic [1:0]  addr_w;
    logic [7:0]  err_cnt_w;

    always #5 clk = ~clk;

    m_enc_imm #(.ADDR_W(10), .BASE(0)) u_dut (
        .w_clk(clk), .w_rst(rst),
        .w_in_valid(in_valid), .w_in_ready(in_ready),
        .w_fmt(fmt), .w_opc(opc), .w_rd(rd), .w_rs1(rs1),
        .w_rs2(rs2), .w_f3(f3), .w_f7(f7), .w_imm(imm),
        .w_out_valid(out_valid), .w_out_ready(out_ready),
        .w_ir(ir), .w_addr(addr),
        .w_err(err), .w_err_cnt(err_cnt)
    );

    m_enc_imm #(.ADDR_W(2), .BASE(0)) u_wrap (
        .w_clk(clk), .w_rst(rst),
        .w_in_valid(in_valid), .w_in_ready(in_ready_w),
        .w_fmt(fmt), .w_opc(opc), .w_rd(rd), .w_rs1(rs1),
        .w_rs2(rs2), .w_f3(f3), .w_f7(f7), .w_imm(imm),
        .w_out_valid(out_valid_w), .w_out_ready(out_ready),
        .w_ir(ir_w), .w_addr(addr_w),
        .w_err(err_w), .w_err_cnt(err_cnt_w)
    );

    typedef struct {
        logic [31:0] word;
        int unsigned idx;
    } exp_t;

    exp_t        q[$];
    int unsigned n_words = 0;
    int unsigned n_err = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fld(input logic [31:0] v,
                                        input int hi, input int lo);
        logic [31:0] mask;
        mask = (32'd1 << (hi - lo + 1)) - 32'd1;
        return (v >> lo) & mask;
    endfunction

    function automatic bit legal_m(input logic [2:0] f,
                                   input logic [6:0] o,
                                   input logic [31:0] im);
        longint s;
        bit ok;
        s = longint'($signed(im));
        case (f)
            3'd0: ok = 1;
            3'd1, 3'd2: ok = (s >= -2048) && (s <= 2047);
            3'd3: ok = (s % 2 == 0) && (s >= -4096) && (s <= 4094);
            3'd4: ok = (im % 4096 == 0);
            3'd5: ok = (s % 2 == 0) && (s >= -1048576) && (s <= 1048574);
            default: ok = 0;
        endcase
        return ok && (o % 4 == 3);
    endfunction

    function automatic logic [31:0] enc_m(
        input logic [2:0] f, input logic [6:0] o, input logic [4:0] d,
        input logic [4:0] a, input logic [4:0] b, input logic [2:0] t3,
        input logic [6:0] t7, input logic [31:0] im);
        logic [31:0] base;
        base = (32'(a) << 15) | (32'(t3) << 12) | 32'(o);
        case (f)
            3'd0: return base | (32'(t7) << 25) | (32'(b) << 20)
                         | (32'(d) << 7);
            3'd1: return base | (fld(im, 11, 0) << 20) | (32'(d) << 7);
            3'd2: return base | (fld(im, 11, 5) << 25) | (32'(b) << 20)
                         | (fld(im, 4, 0) << 7);
            3'd3: return base | (fld(im, 12, 12) << 31)
                         | (fld(im, 10, 5) << 25) | (32'(b) << 20)
                         | (fld(im, 4, 1) << 8) | (fld(im, 11, 11) << 7);
            3'd4: return (im / 4096) * 4096 | (32'(d) << 7) | 32'(o);
            default: return (fld(im, 20, 20) << 31) | (fld(im, 10, 1) << 21)
                         | (fld(im, 11, 11) << 20) | (fld(im, 19, 12) << 12)
                         | (32'(d) << 7) | 32'(o);
        endcase
    endfunction

    // kexp[32] set: directed vector with a hand-computed expected word
    task automatic issue(input logic [2:0] f, input logic [6:0] o,
                         input logic [4:0] d, input logic [4:0] a,
                         input logic [4:0] b, input logic [2:0] t3,
                         input logic [6:0] t7, input logic [31:0] im,
                         input bit ordy, input logic [32:0] kexp);
        bit acc;
        int waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        fmt = f; opc = o; rd = d; rs1 = a; rs2 = b;
        f3 = t3; f7 = t7; imm = im;
        in_valid = 1'b1;
        out_ready = ordy;
        forever begin
            #1 acc = in_ready;
            @(posedge clk);
            if (acc) begin
                if (legal_m(f, o, im)) begin
                    e.word = kexp[32] ? kexp[31:0]
                                      : enc_m(f, o, d, a, b, t3, t7, im);
                    e.idx = n_words;
                    n_words++;
                    q.push_back(e);
                end else begin
                    n_err++;
                end
                break;
            end
            waited++;
            if (waited > 20) begin
                chk("issue_timeout", 32'(waited), 32'd0);
                break;
            end
            @(negedge clk);
            if (waited > 3) out_ready = 1'b1;
        end
    endtask

    task automatic idle(input int n, input bit ordy);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            out_ready = ordy;
            @(posedge clk);
        end
    endtask

    function automatic logic [31:0] pick_imm();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 6))
            0: return r;
            1: return {{20{r[11]}}, r[11:0]};
            2: return {{19{r[12]}}, r[12:1], 1'b0};
            3: return {r[31:12], 12'd0};
            4: return {{11{r[20]}}, r[20:1], 1'b0};
            5: case ($urandom_range(0, 9))
                   0: return 32'd2047;
                   1: return 32'hFFFF_F800;
                   2: return 32'd2048;
                   3: return 32'hFFFF_F7FF;
                   4: return 32'd4094;
                   5: return 32'hFFFF_F000;
                   6: return 32'd4096;
                   7: return 32'd1048574;
                   8: return 32'hFFF0_0000;
                   default: return 32'd1048576;
               endcase
            default: return 32'($urandom_range(0, 15)) - 32'd8;
        endcase
    endfunction

    // Monitor: compares the presented word against the scoreboard
    initial begin
        bit          stall;
        logic [31:0] s_ir;
        logic [9:0]  s_addr;
        exp_t        e;
        stall = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                stall = 0;
                continue;
            end
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("out_valid_w", 32'(out_valid_w), 32'(q.size() != 0));
            chk("in_ready", 32'(in_ready),
                32'((q.size() == 0) || out_ready));
            chk("err", 32'(err), 32'(n_err != 0));
            chk("err_cnt", 32'(err_cnt), n_err > 255 ? 32'd255 : n_err);
            chk("err_cnt_w", 32'(err_cnt_w), n_err > 255 ? 32'd255 : n_err);
            if (stall) begin
                chk("bp_ir_stable", ir, s_ir);
                chk("bp_addr_stable", 32'(addr), 32'(s_addr));
            end
            stall = out_valid && !out_ready;
            s_ir = ir;
            s_addr = addr;
            if (out_valid && out_ready && q.size() != 0) begin
                e = q.pop_front();
                chk("ir", ir, e.word);
                chk("addr", 32'(addr), 32'(10'(e.idx)));
                chk("ir_w", ir_w, e.word);
                chk("addr_wrap", 32'(addr_w), 32'(2'(e.idx)));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst = 1'b1;
        #3;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ir", ir, 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        issue(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1,
              {1'b1, 32'h0050_0093});
        issue(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1,
              {1'b1, 32'h0020_A423});
        issue(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 1,
              {1'b1, 32'hFE20_8EE3});
        issue(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1,
              {1'b1, 32'h1234_52B7});
        issue(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1,
              {1'b1, 32'h0000_006F});
        idle(2, 1);

        issue(3'd0, 7'h33, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 32'd0, 0, 33'd0);
        idle(3, 0);
        idle(2, 1);

        issue(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1, 33'd0);
        issue(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 1, 33'd0);
        issue(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1, 33'd0);
        idle(2, 1);
        chk("illegal_cnt3", 32'(err_cnt), 32'd3);
        issue(3'd1, 7'h13, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 32'd1, 1, 33'd0);

        for (int k = 0; k < 400; k++) begin
            logic [6:0] o;
            o = 7'($urandom);
            if ($urandom_range(0, 3) != 0) o[1:0] = 2'b11;
            if ($urandom_range(0, 9) == 0) idle(1, 1'($urandom));
            issue(3'($urandom_range(0, 7)), o, 5'($urandom), 5'($urandom),
                  5'($urandom), 3'($urandom), 7'($urandom), pick_imm(),
                  $urandom_range(0, 3) != 0, 33'd0);
        end

        for (int k = 0; k < 260; k++) begin
            issue(3'd6, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1,
                  33'd0);
        end
        idle(2, 1);
        chk("err_cnt_sat", 32'(err_cnt), 32'd255);

        issue(3'd1, 7'h13, 5'd7, 5'd1, 5'd0, 3'd0, 7'd0, 32'd9, 0, 33'd0);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        #3;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_addr", 32'(addr), 32'd0);
        chk("async_rst_addr_w", 32'(addr_w), 32'd0);
        chk("async_rst_err", 32'(err), 32'd0);
        chk("async_rst_cnt", 32'(err_cnt), 32'd0);
        q.delete();
        n_words = 0;
        n_err = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        issue(3'd4, 7'h17, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCD_E000, 1,
              33'd0);
        w = 0;
        while (q.size() != 0 && w < 20) begin
            idle(1, 1);
            w++;
        end
        idle(1, 1);
        chk("drain", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
